// File: rtl/tt_trng_ctrl.sv
// Sequencing controller for the ring-oscillator TRNG: ring warm-up, word assembly,
// repetition-count health test and valid/ready word delivery.
module tt_trng_ctrl #(
  parameter int WARMUP_CYCLES = 64,
  parameter int WORD_W        = 8,
  parameter int REP_LIMIT     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              raw_bit,
  input  logic              word_ready,
  input  logic              fault_clr,
  output logic              ring_en,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              busy,
  output logic              fault
);

  localparam int WCNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int BCNT_W = $clog2(WORD_W);

  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WARM_ONE  = WCNT_W'(1);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(WORD_W - 1);
  localparam logic [BCNT_W-1:0] BIT_ONE   = BCNT_W'(1);
  localparam logic [7:0]        REP_MAX   = 8'(REP_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COLLECT,
    S_PRESENT,
    S_FAULT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WCNT_W-1:0] r_warm_cnt;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [7:0]        r_rep_cnt;
  logic [7:0]        w_rep_nxt;
  logic              r_prev;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] w_shift_nxt;
  logic [WORD_W-1:0] r_word;
  logic              w_collect;
  logic              w_rep_trip;
  logic              w_word_done;

  // A bit is only taken when COLLECT is not being aborted on the same edge.
  assign w_collect   = (r_state == S_COLLECT) && req;
  assign w_shift_nxt = {r_shift[WORD_W-2:0], raw_bit};
  assign w_word_done = (r_bit_cnt == BIT_LAST);

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rep_nxt = 8'd1;
    if ((r_bit_cnt != '0) && (raw_bit == r_prev)) begin
      w_rep_nxt = (r_rep_cnt >= REP_MAX) ? REP_MAX : r_rep_cnt + 8'd1;
    end
  end

  assign w_rep_trip = (w_rep_nxt >= REP_MAX);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) w_state_nxt = S_WARMUP;
      end
      S_WARMUP: begin
        if (!req)                          w_state_nxt = S_IDLE;
        else if (r_warm_cnt == WARM_LAST)  w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (!req)             w_state_nxt = S_IDLE;
        else if (w_rep_trip)  w_state_nxt = S_FAULT;
        else if (w_word_done) w_state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        // word_valid is high throughout PRESENT, so word_ready alone completes the handshake.
        if (word_ready) w_state_nxt = req ? S_COLLECT : S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the shift register and word holding register are plain flops, not a
  // memory array, so they take the asynchronous reset like the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm_cnt <= '0;
      r_bit_cnt  <= '0;
      r_rep_cnt  <= '0;
      r_prev     <= 1'b0;
      r_shift    <= '0;
      r_word     <= '0;
    end else begin
      r_warm_cnt <= (r_state == S_WARMUP) ? r_warm_cnt + WARM_ONE : '0;
      // Any exit from COLLECT (abort, fault, completion) rearms the bit counter.
      r_bit_cnt  <= (w_collect && (w_state_nxt == S_COLLECT)) ? r_bit_cnt + BIT_ONE : '0;
      if (w_collect) begin
        r_shift   <= w_shift_nxt;
        r_prev    <= raw_bit;
        r_rep_cnt <= w_rep_nxt;
      end
      if (w_collect && (w_state_nxt == S_PRESENT)) r_word <= w_shift_nxt;
    end
  end

  assign ring_en    = (r_state == S_WARMUP) || (r_state == S_COLLECT) || (r_state == S_PRESENT);
  assign busy       = ring_en;
  assign word_valid = (r_state == S_PRESENT);
  assign fault      = (r_state == S_FAULT);
  assign word_out   = r_word;

endmodule

// File: tb/tb_tt_trng_ctrl.sv
// Scoreboard bench for tt_trng_ctrl: directed bit streams, expected words queued
// at stimulus time and checked by a monitor on each valid/ready handshake.
module tb_tt_trng_ctrl;

  localparam int WARM = 4;
  localparam int WW   = 8;
  localparam int REP  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          raw_bit;
  logic          word_ready;
  logic          fault_clr;
  logic          ring_en;
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          busy;
  logic          fault;

  int            total = 0;
  int            bad   = 0;
  logic [WW-1:0] sb_q[$];

  always #5 clk = ~clk;

  tt_trng_ctrl #(
    .WARMUP_CYCLES(WARM),
    .WORD_W       (WW),
    .REP_LIMIT    (REP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .raw_bit   (raw_bit),
    .word_ready(word_ready),
    .fault_clr (fault_clr),
    .ring_en   (ring_en),
    .word_out  (word_out),
    .word_valid(word_valid),
    .busy      (busy),
    .fault     (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_st(input string tag, input logic e_ring, input logic e_valid,
                          input logic e_busy, input logic e_fault);
    check({tag, "_ring_en"}, 32'(ring_en), 32'(e_ring));
    check({tag, "_word_valid"}, 32'(word_valid), 32'(e_valid));
    check({tag, "_busy"}, 32'(busy), 32'(e_busy));
    check({tag, "_fault"}, 32'(fault), 32'(e_fault));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic warm();
    repeat (WARM) begin
      raw_bit = 1'($urandom_range(1, 0));
      tick();
    end
  endtask

  // Drives bit positions lo..hi of w, MSB first, one bit per edge.
  task automatic send_bits(input logic [WW-1:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      raw_bit = w[WW-1-i];
      tick();
    end
  endtask

  // Monitor: each handshake consumes one expected word.
  initial begin
    logic [WW-1:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst_n && word_valid && word_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_word: got %0h expected no word at %0t", word_out, $time);
        end else begin
          exp_w = sb_q.pop_front();
          check("sb_word", 32'(word_out), 32'(exp_w));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    req        = 1'b0;
    raw_bit    = 1'b0;
    word_ready = 1'b0;
    fault_clr  = 1'b0;

    // Reset held with random inputs.
    repeat (3) begin
      @(negedge clk);
      req        = 1'($urandom_range(1, 0));
      raw_bit    = 1'($urandom_range(1, 0));
      word_ready = 1'($urandom_range(1, 0));
      fault_clr  = 1'($urandom_range(1, 0));
      #1;
      check_st("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_hold_word", 32'(word_out), 32'h0);
    end
    req = 1'b0; raw_bit = 1'b0; word_ready = 1'b0; fault_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    check_st("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_rel_word", 32'(word_out), 32'h0);

    // Single word B2 from cold start, then handshake with req low.
    word_ready = 1'b1;
    req = 1'b1;
    tick();
    check_st("sw_e0", 1'b1, 1'b0, 1'b1, 1'b0);
    warm();
    check_st("sw_warm", 1'b1, 1'b0, 1'b1, 1'b0);
    sb_q.push_back(8'hB2);
    send_bits(8'hB2, 0, 6);
    check_st("sw_7bits", 1'b1, 1'b0, 1'b1, 1'b0);
    send_bits(8'hB2, 7, 7);
    check_st("sw_done", 1'b1, 1'b1, 1'b1, 1'b0);
    check("sw_word", 32'(word_out), 32'hB2);
    req = 1'b0;
    tick();
    check_st("sw_hs_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure on word 69, then continuous mode into 5A.
    word_ready = 1'b0;
    req = 1'b1;
    tick();
    warm();
    sb_q.push_back(8'h69);
    send_bits(8'h69, 0, 7);
    check_st("bp_valid", 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) begin
      raw_bit = 1'($urandom_range(1, 0));
      tick();
      check("bp_hold_valid", 32'(word_valid), 32'h1);
      check("bp_hold_word", 32'(word_out), 32'h69);
    end
    word_ready = 1'b1;
    tick();
    check_st("cm_after_h", 1'b1, 1'b0, 1'b1, 1'b0);
    sb_q.push_back(8'h5A);
    send_bits(8'h5A, 0, 6);
    check("cm_7bits_valid", 32'(word_valid), 32'h0);
    send_bits(8'h5A, 7, 7);
    check_st("cm_done", 1'b1, 1'b1, 1'b1, 1'b0);
    check("cm_word", 32'(word_out), 32'h5A);
    req = 1'b0;
    tick();
    check_st("cm_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Health fault on a constant-1 stream.
    req = 1'b1;
    tick();
    warm();
    for (int i = 0; i < REP - 1; i++) begin
      raw_bit = 1'b1;
      tick();
      check_st("hf_bit", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    raw_bit = 1'b1;
    tick();
    check_st("hf_trip", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      raw_bit = 1'($urandom_range(1, 0));
      tick();
      check_st("hf_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("hf_word_kept", 32'(word_out), 32'h5A);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check_st("hf_clr", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_st("hf_restart", 1'b1, 1'b0, 1'b1, 1'b0);
    warm();
    sb_q.push_back(8'hA6);
    send_bits(8'hA6, 0, 6);
    check("hf_re_7bits_valid", 32'(word_valid), 32'h0);
    send_bits(8'hA6, 7, 7);
    check_st("hf_re_done", 1'b1, 1'b1, 1'b1, 1'b0);
    check("hf_re_word", 32'(word_out), 32'hA6);

    // Fault on the last bit of a word wins over completion (handshake keeps req high).
    tick();
    send_bits(8'hAF, 0, 6);
    check_st("fp_7bits", 1'b1, 1'b0, 1'b1, 1'b0);
    send_bits(8'hAF, 7, 7);
    check_st("fp_trip", 1'b0, 1'b0, 1'b0, 1'b1);
    check("fp_word_kept", 32'(word_out), 32'hA6);
    fault_clr = 1'b1;
    req = 1'b0;
    tick();
    fault_clr = 1'b0;
    check_st("fp_clr", 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort after 3 collected bits, then a full restart.
    req = 1'b1;
    tick();
    warm();
    send_bits(8'h96, 0, 2);
    req = 1'b0;
    raw_bit = 1'($urandom_range(1, 0));
    tick();
    check_st("ab_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("ab_word_kept", 32'(word_out), 32'hA6);
    req = 1'b1;
    tick();
    check_st("ab_e0", 1'b1, 1'b0, 1'b1, 1'b0);
    warm();
    check_st("ab_warm", 1'b1, 1'b0, 1'b1, 1'b0);
    sb_q.push_back(8'h96);
    send_bits(8'h96, 0, 6);
    check("ab_7bits_valid", 32'(word_valid), 32'h0);
    send_bits(8'h96, 7, 7);
    check_st("ab_done", 1'b1, 1'b1, 1'b1, 1'b0);
    check("ab_word", 32'(word_out), 32'h96);
    req = 1'b0;
    tick();
    check_st("ab_hs_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while a word is presented.
    word_ready = 1'b0;
    req = 1'b1;
    tick();
    warm();
    send_bits(8'h4D, 0, 7);
    check_st("rm_valid", 1'b1, 1'b1, 1'b1, 1'b0);
    check("rm_word", 32'(word_out), 32'h4D);
    #2;
    rst_n = 1'b0;
    #1;
    check_st("rm_async", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rm_async_word", 32'(word_out), 32'h0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_st("rm_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rm_idle_word", 32'(word_out), 32'h0);

    repeat (2) tick();
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
